// File: rtl/qpu_exu_bjp_commit_pkg.sv
// Shared definitions for the BJP commit stage: PC width, FSM state codes, redirect target helper.
// Also carries the QPU_defines macros (`QPU_PC_SIZE, `QPU_BJP_CMT_ST_*) used by the package.
// Pure definitions; no logic, no latency, no backpressure.
`ifndef QPU_DEFINES_V
`define QPU_DEFINES_V
`define QPU_PC_SIZE 32
`define QPU_BJP_CMT_ST_IDLE 1'b0
`define QPU_BJP_CMT_ST_FLUSH 1'b1
`endif

package qpu_exu_bjp_commit_pkg;

  localparam int PC_W = `QPU_PC_SIZE;

  // Sequential fall-through distance for a not-taken branch.
  localparam logic [PC_W-1:0] SEQ_STEP = PC_W'(4);

  typedef enum logic [0:0] {
    ST_IDLE  = `QPU_BJP_CMT_ST_IDLE,
    ST_FLUSH = `QPU_BJP_CMT_ST_FLUSH
  } cmt_state_e;

  // Corrected fetch PC for a resolved branch; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] bjp_redirect_pc(
    input logic [PC_W-1:0] pc,
    input logic [PC_W-1:0] imm,
    input logic            rslv
  );
    return rslv ? (pc + imm) : (pc + SEQ_STEP);
  endfunction

endpackage

// File: rtl/qpu_bjp_perf_cnt.sv
// Saturating event counter with synchronous clear; present only when QPU_BJP_PERF_CNT_EN is defined.
// Latency: count visible one cycle after the increment or clear.
// Backpressure: none; clear wins over a same-cycle increment, counter sticks at all-ones.
`ifdef QPU_BJP_PERF_CNT_EN
module qpu_bjp_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/qpu_exu_bjp_commit.sv
// Branch commit stage: retires BJP results, issues a registered IFU redirect on mispredict.
// Latency: flush_o_valid one cycle after a mispredicted commit is accepted; perf counters optional (QPU_BJP_PERF_CNT_EN).
// Backpressure: cmt_i_ready drops while a redirect is pending; the redirect is held until flush_o_ready.
module qpu_exu_bjp_commit
  import qpu_exu_bjp_commit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic             cmt_i_prdt,
  input  logic             cmt_i_rslv,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic [PC_W-1:0]  cmt_i_imm,
  output logic             flush_o_valid,
  input  logic             flush_o_ready,
  output logic [PC_W-1:0]  flush_o_pc,
  output logic             cmt_o_mispred,
  input  logic             perf_i_clr,
  output logic [CNT_W-1:0] perf_o_bjp_cnt,
  output logic [CNT_W-1:0] perf_o_mis_cnt
);

  cmt_state_e      state_q;
  cmt_state_e      state_d;
  logic            flush_vld_q;
  logic            flush_vld_d;
  logic [PC_W-1:0] flush_pc_q;
  logic [PC_W-1:0] flush_pc_d;
  logic            cmt_acc;
  logic            cmt_mis;

  // Commit handshake: only IDLE accepts, and never while reset is asserted.
  always_comb begin
    cmt_i_ready = (state_q == ST_IDLE) && !rst;
    cmt_acc     = cmt_i_valid && cmt_i_ready;
    cmt_mis     = cmt_acc && (cmt_i_prdt != cmt_i_rslv);
  end

  assign cmt_o_mispred = cmt_mis;

  // Next state and redirect PC; the PC is captured only at mispredict acceptance so it holds during FLUSH.
  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (cmt_mis) begin
          state_d    = ST_FLUSH;
          flush_pc_d = bjp_redirect_pc(cmt_i_pc, cmt_i_imm, cmt_i_rslv);
        end
      end
      ST_FLUSH: begin
        if (flush_o_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    flush_vld_d = (state_d == ST_FLUSH);
  end

  // FSM and registered redirect outputs; reset drops any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_vld_q <= 1'b0;
      flush_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_vld_q <= flush_vld_d;
      flush_pc_q  <= flush_pc_d;
    end
  end

  assign flush_o_valid = flush_vld_q;
  assign flush_o_pc    = flush_pc_q;

`ifdef QPU_BJP_PERF_CNT_EN
  qpu_bjp_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_bjp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (perf_i_clr),
    .inc_i (cmt_acc),
    .cnt_o (perf_o_bjp_cnt)
  );

  qpu_bjp_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_mis_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (perf_i_clr),
    .inc_i (cmt_mis),
    .cnt_o (perf_o_mis_cnt)
  );
`else
  // Counters compiled out: ports read zero and the clear input has no effect.
  logic unused_perf_clr;
  assign unused_perf_clr = perf_i_clr;
  assign perf_o_bjp_cnt  = '0;
  assign perf_o_mis_cnt  = '0;
`endif

endmodule
